// File: rtl/number_token_ctrl.sv
// number_token_ctrl
// Sequences received bytes through the byte classifier and assembles runs of
// ASCII decimal digits into unsigned binary values.
//
// Each byte passes through three states: IDLE (take the byte), ISSUE (pulse
// the classifier enable) and EVAL (act on the registered classifier flags).
// This gives a throughput of one byte per three cycles.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   rx_data/valid   incoming byte, valid/ready handshake with rx_ready
//   flush           end the current token as if a delimiter had arrived
//   cmp_data/en     byte and one-cycle enable sent to the classifier
//   cmp_data_out    byte registered by the classifier
//   cmp_is_number   classifier flag for an ASCII digit
//   cmp_is_white    classifier flag for a delimiter (' ' or '-')
//   num_value       last completed value, held until the next num_valid
//   num_valid       one-cycle pulse when num_value has been updated
//   ovf             one-cycle pulse when a token exceeded 2^VAL_W-1
//   err             one-cycle pulse when a byte was neither digit nor delimiter
module number_token_ctrl #(
    parameter int VAL_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    input  logic             flush,
    output logic [7:0]       cmp_data,
    output logic             cmp_en,
    input  logic [7:0]       cmp_data_out,
    input  logic             cmp_is_number,
    input  logic             cmp_is_white,
    output logic [VAL_W-1:0] num_value,
    output logic             num_valid,
    output logic             ovf,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        EVAL
    } state_t;

    // Four extra bits hold acc*10+9 without wrapping, so overflow is detected
    // by a plain magnitude compare.
    localparam int ACC_W = VAL_W + 4;
    localparam logic [ACC_W-1:0] MAX_VAL = {4'b0000, {VAL_W{1'b1}}};

    state_t           state;
    logic [VAL_W-1:0] acc;
    logic             in_tok;
    logic             tok_ovf;
    logic [ACC_W-1:0] next_acc;
    logic             next_ovf;

    // The digit is the full classifier byte minus ASCII '0'. The result is
    // only used when cmp_is_number is set, so it is always 0..9 in that case.
    always_comb begin
        next_acc = {4'b0000, acc} * ACC_W'(10)
                 + {{(ACC_W-8){1'b0}}, cmp_data_out - 8'd48};
        next_ovf = next_acc > MAX_VAL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rx_ready  <= 1'b0;
            cmp_data  <= 8'd0;
            cmp_en    <= 1'b0;
            acc       <= '0;
            in_tok    <= 1'b0;
            tok_ovf   <= 1'b0;
            num_value <= '0;
            num_valid <= 1'b0;
            ovf       <= 1'b0;
            err       <= 1'b0;
        end else begin
            num_valid <= 1'b0;
            ovf       <= 1'b0;
            err       <= 1'b0;

            case (state)
                IDLE: begin
                    // rx_ready is still low on the first cycle after reset,
                    // so the byte is only taken once ready is visible.
                    if (rx_valid && rx_ready) begin
                        cmp_data <= rx_data;
                        cmp_en   <= 1'b1;
                        rx_ready <= 1'b0;
                        state    <= ISSUE;
                    end else begin
                        rx_ready <= 1'b1;
                        if (flush && in_tok) begin
                            if (tok_ovf) begin
                                ovf <= 1'b1;
                            end else begin
                                num_value <= acc;
                                num_valid <= 1'b1;
                            end
                            acc     <= '0;
                            in_tok  <= 1'b0;
                            tok_ovf <= 1'b0;
                        end
                    end
                end

                ISSUE: begin
                    cmp_en <= 1'b0;
                    state  <= EVAL;
                end

                EVAL: begin
                    rx_ready <= 1'b1;
                    state    <= IDLE;
                    if (cmp_is_number) begin
                        in_tok <= 1'b1;
                        // On overflow acc keeps its old value. The token is
                        // discarded anyway once it terminates.
                        if (next_ovf) begin
                            tok_ovf <= 1'b1;
                        end else begin
                            acc <= next_acc[VAL_W-1:0];
                        end
                    end else if (cmp_is_white) begin
                        if (in_tok) begin
                            if (tok_ovf) begin
                                ovf <= 1'b1;
                            end else begin
                                num_value <= acc;
                                num_valid <= 1'b1;
                            end
                            acc     <= '0;
                            in_tok  <= 1'b0;
                            tok_ovf <= 1'b0;
                        end
                    end else begin
                        err     <= 1'b1;
                        acc     <= '0;
                        in_tok  <= 1'b0;
                        tok_ovf <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
